// File: rtl/hpi_txn_ctrl_if.sv
// ---------------------------------------------------------------------------
// hpi_txn_ctrl_if
// Request/response bundle between the two requesters (port 0 = CPU,
// port 1 = hardware) and the HPI transaction controller.
//   reqN_valid/we/addr/wdata : request from port N (master -> slave)
//   reqN_ready               : one-cycle accept pulse (slave -> master)
//   rspN_valid               : one-cycle completion pulse (slave -> master)
//   rsp_data                 : read data, shared by both ports
// ---------------------------------------------------------------------------
interface hpi_txn_ctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_we;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_we;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [15:0] rsp_data;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/hpi_txn_ctrl.sv
// ---------------------------------------------------------------------------
// hpi_txn_ctrl
// Sequences single read/write transactions onto the EZ-OTG HPI pad
// interface for two requesters, arbitrated round-robin.
//   Clk, Reset   : rising-edge clock, synchronous active-high reset
//   txn          : hpi_txn_ctrl_if.slave request/response bundle
//   busy         : high whenever the controller is not IDLE
//   hpi_address, hpi_data_out, hpi_data_in : pad address / write / read data
//   hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n : active-low pad strobes
// Phases: SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (1) -> IDLE.
// Optional build macro HPI_RST_SEQ_EN adds a chip reset sequence after
// Reset: RST_HOLD (hpi_reset_n low, RST_CYC) then RST_WAIT (RST_CYC).
// Without it, hpi_reset_n is tied high and Reset lands directly in IDLE.
// ---------------------------------------------------------------------------
module hpi_txn_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int RST_CYC    = 1000
) (
  input  logic          Clk,
  input  logic          Reset,
  hpi_txn_ctrl_if.slave txn,
  output logic          busy,
  output logic [1:0]    hpi_address,
  output logic [15:0]   hpi_data_out,
  input  logic [15:0]   hpi_data_in,
  output logic          hpi_r_n,
  output logic          hpi_w_n,
  output logic          hpi_cs_n,
  output logic          hpi_reset_n
);

  // One down-counter serves every timed state, so it is sized to the
  // longest of the three durations.
  localparam int PH_MAX  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_MAX = (RST_CYC > PH_MAX) ? RST_CYC : PH_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);

  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

`ifdef HPI_RST_SEQ_EN
  localparam logic [2:0]       ST_RST_HOLD = 3'd0;
  localparam logic [2:0]       ST_RST_WAIT = 3'd1;
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
  localparam logic [2:0]       ST_RESET    = ST_RST_HOLD;
  localparam logic [CNT_W-1:0] CNT_RESET   = RST_LOAD;
  localparam logic             BUSY_RESET  = 1'b1;
`else
  localparam logic [2:0]       ST_RESET    = ST_IDLE;
  localparam logic [CNT_W-1:0] CNT_RESET   = CNT_ZERO;
  localparam logic             BUSY_RESET  = 1'b0;
`endif

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             last_strobe_s;
  // last_grant_r also identifies the port owning the transaction in flight.
  logic             last_grant_r;
  logic             we_r;
  logic [1:0]       hpi_address_r;
  logic [15:0]      hpi_data_out_r;
  logic             hpi_cs_n_r;
  logic             hpi_r_n_r;
  logic             hpi_w_n_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic [15:0]      rsp_data_r;
  logic             busy_r;

  // Round-robin pick: on contention the port not granted last wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (txn.req0_valid && txn.req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = !last_grant_r;
    end else begin
      grant0_s = txn.req0_valid;
      grant1_s = txn.req1_valid;
    end
  end

  // Next-state and phase counter; counters stop at zero and are reloaded on exit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (txn.req0_valid || txn.req1_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_SETUP;
          cnt_nxt_s   = SETUP_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_STROBE;
          cnt_nxt_s   = STROBE_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_HOLD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_HOLD: begin
        state_nxt_s = ST_IDLE;
      end
`ifdef HPI_RST_SEQ_EN
      ST_RST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RST_WAIT;
          cnt_nxt_s   = RST_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Read data is sampled in the last strobe cycle, after the pad's two register stages.
  assign last_strobe_s = (state_r == ST_STROBE) && (cnt_r == CNT_ZERO);

  // State, latched request and registered pad/response outputs (decoded from next state).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r        <= ST_RESET;
      cnt_r          <= CNT_RESET;
      last_grant_r   <= 1'b1;
      we_r           <= 1'b0;
      hpi_address_r  <= 2'd0;
      hpi_data_out_r <= 16'd0;
      hpi_cs_n_r     <= 1'b1;
      hpi_r_n_r      <= 1'b1;
      hpi_w_n_r      <= 1'b1;
      rsp0_valid_r   <= 1'b0;
      rsp1_valid_r   <= 1'b0;
      rsp_data_r     <= 16'd0;
      busy_r         <= BUSY_RESET;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        last_grant_r   <= grant1_s;
        we_r           <= grant1_s ? txn.req1_we    : txn.req0_we;
        hpi_address_r  <= grant1_s ? txn.req1_addr  : txn.req0_addr;
        hpi_data_out_r <= grant1_s ? txn.req1_wdata : txn.req0_wdata;
      end
      hpi_cs_n_r   <= !((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) ||
                        (state_nxt_s == ST_HOLD));
      hpi_w_n_r    <= !((state_nxt_s == ST_STROBE) && we_r);
      hpi_r_n_r    <= !((state_nxt_s == ST_STROBE) && !we_r);
      rsp0_valid_r <= last_strobe_s && !last_grant_r;
      rsp1_valid_r <= last_strobe_s && last_grant_r;
      if (last_strobe_s && !we_r) begin
        rsp_data_r <= hpi_data_in;
      end
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef HPI_RST_SEQ_EN
  logic hpi_reset_n_r;

  // Chip reset pin is low only while in RST_HOLD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hpi_reset_n_r <= 1'b0;
    end else begin
      hpi_reset_n_r <= (state_nxt_s != ST_RST_HOLD);
    end
  end

  assign hpi_reset_n = hpi_reset_n_r;
`else
  assign hpi_reset_n = 1'b1;
`endif

  // Accept pulse is combinational so it lands in the same IDLE cycle as the request.
  assign txn.req0_ready = accept_s && grant0_s && !Reset;
  assign txn.req1_ready = accept_s && grant1_s && !Reset;
  assign txn.rsp0_valid = rsp0_valid_r;
  assign txn.rsp1_valid = rsp1_valid_r;
  assign txn.rsp_data   = rsp_data_r;
  assign busy           = busy_r;
  assign hpi_address    = hpi_address_r;
  assign hpi_data_out   = hpi_data_out_r;
  assign hpi_cs_n       = hpi_cs_n_r;
  assign hpi_r_n        = hpi_r_n_r;
  assign hpi_w_n        = hpi_w_n_r;

endmodule

// File: tb/tb_hpi_txn_ctrl.sv
`timescale 1ns/1ps
module tb_hpi_txn_ctrl;
  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 4;
  localparam int RST_CYC    = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        busy;
  logic [1:0]  hpi_address;
  logic [15:0] hpi_data_out;
  logic [15:0] hpi_data_in;
  logic        hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n;

  always #5 Clk = ~Clk;

  hpi_txn_ctrl_if bus();

  hpi_txn_ctrl #(.SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .RST_CYC(RST_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .txn(bus), .busy(busy),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
    .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_cs_n(hpi_cs_n), .hpi_reset_n(hpi_reset_n)
  );

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [6:0]  exp_w_lo;  // bit k-1 = w_n low in cycle k after accept
    logic [6:0]  exp_r_lo;
  } vec_t;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[6];
  vec_t        boot;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  bit          last_port_m;
  logic [15:0] rdata_m;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit valid, input bit we,
                         input logic [1:0] addr, input logic [15:0] wdata);
    if (port) begin
      bus.req1_valid = valid; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end else begin
      bus.req0_valid = valid; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end
  endtask

  // Model: the response carries the last read value (writes leave it unchanged).
  task automatic expect_rsp(input bit port, input bit we, input logic [15:0] din);
    exp_t e;
    if (!we) rdata_m = din;
    e.port = port;
    e.data = rdata_m;
    sb_q.push_back(e);
    last_port_m = port;
  endtask

  // Scoreboard consumer and strobe exclusivity monitor.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp0=%0b rsp1=%0b with nothing outstanding",
                 bus.rsp0_valid, bus.rsp1_valid);
      end else begin
        e = sb_q.pop_front();
        check("rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, e.port ? 2'b10 : 2'b01);
        check("rsp_data", bus.rsp_data, e.data);
      end
    end
    if (!hpi_r_n || !hpi_w_n) check("strobe_excl", !hpi_r_n && !hpi_w_n, 0);
  end

  // Call at posedge+#1; returns at posedge+#1 after the transaction's idle cycle.
  task automatic do_txn(input vec_t v, input string tag);
    int waits;
    logic [6:0] cs_lo, w_lo, r_lo, rp_lo, ro_lo;
    waits = 0; cs_lo = '0; w_lo = '0; r_lo = '0; rp_lo = '0; ro_lo = '0;
    hpi_data_in = ~v.din;
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(negedge Clk);
    while (!(v.port ? bus.req1_ready : bus.req0_ready) && waits < 64) begin
      waits++;
      @(negedge Clk);
    end
    check({tag, "_accept_wait"}, waits, 0);
    check({tag, "_other_ready"}, v.port ? bus.req0_ready : bus.req1_ready, 0);
    expect_rsp(v.port, v.we, v.din);
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk); #1;
      if (k == 1) set_req(v.port, 1'b0, ~v.we, ~v.addr, ~v.wdata);
      hpi_data_in = (k == 5) ? v.din : ~v.din;
      @(negedge Clk);
      cs_lo[k-1] = !hpi_cs_n;
      w_lo[k-1]  = !hpi_w_n;
      r_lo[k-1]  = !hpi_r_n;
      rp_lo[k-1] = v.port ? bus.rsp1_valid : bus.rsp0_valid;
      ro_lo[k-1] = v.port ? bus.rsp0_valid : bus.rsp1_valid;
      if (k == 3) begin
        check({tag, "_addr"}, hpi_address, v.addr);
        check({tag, "_data_out"}, hpi_data_out, v.wdata);
        check({tag, "_busy"}, busy, 1);
      end
    end
    check({tag, "_cs_window"}, cs_lo, 7'b0111111);
    check({tag, "_w_window"}, w_lo, v.exp_w_lo);
    check({tag, "_r_window"}, r_lo, v.exp_r_lo);
    check({tag, "_rsp_own"}, rp_lo, 7'b0100000);
    check({tag, "_rsp_other"}, ro_lo, 7'b0000000);
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired before the test finished");
    $fatal(1);
  end

  initial begin
    int w;
    bit exp_port;
    int prev_acc;
    Reset = 1'b1;
    hpi_data_in = 16'h0000;
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    set_req(1'b0, 1'b1, 1'b1, 2'd0, 16'h0001);
    rdata_m = 16'h0000;
    last_port_m = 1'b1;
    boot    = '{1'b0, 1'b1, 2'd0, 16'h0001, 16'h0000, 7'b0011110, 7'b0000000};
    vecs[0] = '{1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 7'b0011110, 7'b0000000};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 16'h0000, 16'hBEEF, 7'b0000000, 7'b0011110};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 16'hFFFF, 16'h1357, 7'b0011110, 7'b0000000};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 16'h2468, 16'h5A5A, 7'b0000000, 7'b0011110};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 16'hA5C3, 16'h0000, 7'b0011110, 7'b0000000};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h0F0F, 7'b0000000, 7'b0011110};

    // Reset values (request pending on port 0 must not be accepted)
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_cs_n", hpi_cs_n, 1);
    check("rst_r_n", hpi_r_n, 1);
    check("rst_w_n", hpi_w_n, 1);
    check("rst_addr", hpi_address, 0);
    check("rst_data_out", hpi_data_out, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
    check("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
`ifdef HPI_RST_SEQ_EN
    check("rst_busy", busy, 1);
    check("rst_hpi_reset_n", hpi_reset_n, 0);
`else
    check("rst_busy", busy, 0);
    check("rst_hpi_reset_n", hpi_reset_n, 1);
`endif
    @(posedge Clk); #1;
    Reset = 1'b0;
`ifdef HPI_RST_SEQ_EN
    for (int i = 0; i < 2 * RST_CYC; i++) begin
      @(negedge Clk);
      check("seq_ready", bus.req0_ready, 0);
      check("seq_busy", busy, 1);
      check("seq_hpi_reset_n", hpi_reset_n, (i >= RST_CYC) ? 1 : 0);
    end
`endif
    do_txn(boot, "boot");
    check("boot_hpi_reset_n", hpi_reset_n, 1);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Round robin with both ports requesting continuously
    set_req(1'b0, 1'b1, 1'b1, 2'd1, 16'h1111);
    set_req(1'b1, 1'b1, 1'b1, 2'd3, 16'h2222);
    prev_acc = 0;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      @(negedge Clk);
      while (!(bus.req0_ready || bus.req1_ready) && w < 64) begin
        w++;
        @(negedge Clk);
      end
      exp_port = !last_port_m;
      check("rr_grant", {bus.req1_ready, bus.req0_ready}, exp_port ? 2'b10 : 2'b01);
      check("rr_idle_cs", hpi_cs_n, 1);
      if (t > 0) check("rr_interval", cyc_cnt - prev_acc, SETUP_CYC + STROBE_CYC + 2);
      prev_acc = cyc_cnt;
      expect_rsp(exp_port, 1'b1, 16'h0000);
      @(posedge Clk); #1;
    end
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    repeat (8) @(posedge Clk);
    #1;

    // Reset in the middle of a port 0 read strobe
    hpi_data_in = 16'h7777;
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 16'h3333);
    w = 0;
    @(negedge Clk);
    while (!bus.req0_ready && w < 64) begin
      w++;
      @(negedge Clk);
    end
    check("abort_accept", bus.req0_ready, 1);
    @(posedge Clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_strobe", hpi_r_n, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_cs_n", hpi_cs_n, 1);
    check("abort_r_n", hpi_r_n, 1);
    check("abort_w_n", hpi_w_n, 1);
    check("abort_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    sb_q.delete();
    last_port_m = 1'b1;
    rdata_m = 16'h0000;
    @(posedge Clk); #1;
    Reset = 1'b0;

    // First grant after reset goes to port 0 even though port 0 went last
    set_req(1'b0, 1'b1, 1'b1, 2'd0, 16'hC0DE);
    set_req(1'b1, 1'b1, 1'b1, 2'd1, 16'hD00D);
    w = 0;
    @(negedge Clk);
    while (!(bus.req0_ready || bus.req1_ready) && w < 80) begin
      w++;
      @(negedge Clk);
    end
    check("post_reset_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    expect_rsp(1'b0, 1'b1, 16'h0000);
    @(posedge Clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
